// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural PC and runs the fetch handshake for the
// single-stage core. One imem request at a time (req/gnt, then rvalid). The
// fetched word is held for execute until it retires, and then the next PC is
// chosen. A flush carries an absolute target and discards any in-flight fetch.
//
// Optional feature: define PC_MISALIGN_TRAP_EN to trap on a misaligned redirect
// or flush target instead of silently clearing its low two bits.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        CLK,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_offset,
  input  logic        flush_valid,
  input  logic [31:0] flush_pc,
  output logic        trap_valid,
  output logic [31:0] trap_pc
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        drop;

  logic        retire;
  logic        cf_target;
  logic [31:0] raw_target;
  logic        target_bad;
  logic [31:0] next_pc;

  // Pick the PC that the next fetch goes to: flush beats redirect beats PC+step
  always_comb begin
    retire     = (state == S_HOLD) && inst_valid && inst_ready;
    cf_target  = flush_valid || (retire && redirect_valid);
    raw_target = flush_valid    ? flush_pc :
                 redirect_valid ? (inst_pc + redirect_offset) :
                                  (inst_pc + STEP);
`ifdef PC_MISALIGN_TRAP_EN
    target_bad = cf_target && (raw_target[1:0] != 2'b00);
    next_pc    = target_bad ? RESET_PC : raw_target;
`else
    target_bad = 1'b0;
    next_pc    = cf_target ? {raw_target[31:2], 2'b00} : raw_target;
`endif
  end

  // Fetch FSM with registered outputs; a flush in any state takes priority
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      inst_valid <= 1'b0;
      inst       <= 32'h0;
      inst_pc    <= 32'h0;
      trap_valid <= 1'b0;
      trap_pc    <= 32'h0;
    end else begin
      // A misaligned target is reported for exactly one cycle
      trap_valid <= target_bad;
      trap_pc    <= target_bad ? raw_target : 32'h0;

      if (flush_valid) begin
        // A misaligned flush still goes through the drop path when a response
        // is outstanding, so only one imem transaction can ever be in flight.
        pc         <= next_pc;
        inst_valid <= 1'b0;
        unique case (state)
          S_FETCH: begin
            if (imem_req && imem_gnt) begin
              imem_req <= 1'b0;
              drop     <= 1'b1;
              state    <= S_WAIT;
            end else begin
              imem_req  <= 1'b1;
              imem_addr <= next_pc;
              state     <= S_FETCH;
            end
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              drop      <= 1'b0;
              imem_req  <= 1'b1;
              imem_addr <= next_pc;
              state     <= S_FETCH;
            end else begin
              drop <= 1'b1;
            end
          end
          S_HOLD: begin
            imem_req  <= 1'b1;
            imem_addr <= next_pc;
            state     <= S_FETCH;
          end
          default: begin
            imem_req  <= 1'b1;
            imem_addr <= next_pc;
            state     <= S_FETCH;
          end
        endcase
      end else begin
        unique case (state)
          S_FETCH: begin
            // Request is low only in the first cycle after reset release
            if (!imem_req) begin
              imem_req  <= 1'b1;
              imem_addr <= pc;
            end else if (imem_gnt) begin
              imem_req <= 1'b0;
              state    <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              if (drop) begin
                drop      <= 1'b0;
                imem_req  <= 1'b1;
                imem_addr <= pc;
                state     <= S_FETCH;
              end else begin
                inst       <= imem_rdata;
                inst_pc    <= pc;
                inst_valid <= 1'b1;
                state      <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            // Request the next PC straight away so zero-wait imem sustains one
            // instruction every three cycles
            if (retire) begin
              inst_valid <= 1'b0;
              pc         <= next_pc;
              imem_req   <= 1'b1;
              imem_addr  <= next_pc;
              state      <= S_FETCH;
            end
          end
          default: begin
            drop      <= 1'b0;
            imem_req  <= 1'b1;
            imem_addr <= pc;
            state     <= S_FETCH;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: drives pc_sequencer with a randomized imem responder and
// compares the delivered instruction stream with a program-order PC model.
`timescale 1ns/1ps
module tb_pc_sequencer;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_offset = 32'h0;
  logic        flush_valid = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        trap_valid;
  logic [31:0] trap_pc;

  int tests = 0;
  int fails = 0;

  int gnt_pct  = 100;
  int extra_lo = 0;
  int extra_hi = 0;
  bit pending  = 1'b0;
  int cnt      = 0;
  logic [31:0] pend_addr = 32'h0;

  pc_sequencer #(.RESET_PC(RESET_PC), .PC_STEP(4)) dut (
    .CLK(CLK), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_offset(redirect_offset),
    .flush_valid(flush_valid), .flush_pc(flush_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc)
  );

  always #5 CLK = ~CLK;

  // Instruction memory contents: every address holds a distinct word
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A17;
  endfunction

  // imem responder: random grant, one response per grant after a random delay,
  // and garbage on rdata whenever rvalid is low
  always @(negedge CLK) begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (!reset) begin
      pending = 1'b0;
    end else if (pending) begin
      tests++;
      if (imem_req !== 1'b0) begin
        fails++;
        $display("[TB] FAIL one_outstanding: imem_req=%b while a response is pending, required 0", imem_req);
      end
      cnt--;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pending     = 1'b0;
      end
    end else if (imem_req === 1'b1 && int'($urandom_range(0, 99)) < gnt_pct) begin
      imem_gnt  = 1'b1;
      pend_addr = imem_addr;
      pending   = 1'b1;
      cnt       = 1 + extra_lo + int'($urandom_range(0, extra_hi - extra_lo));
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_offset = 32'h0;
    flush_valid     = 1'b0;
    flush_pc        = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    gnt_pct  = 100;
    extra_lo = 0;
    extra_hi = 0;
    @(negedge CLK);
    reset = 1'b0;
    repeat (2) @(negedge CLK);
    reset = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (inst_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    tests++;
    if ({imem_req, inst_valid, trap_valid} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL reset_flags: req/valid/trap=%b, required 000", {imem_req, inst_valid, trap_valid});
    end
    tests++;
    if (imem_addr !== RESET_PC) begin
      fails++;
      $display("[TB] FAIL reset_addr: imem_addr=%h, required %h", imem_addr, RESET_PC);
    end
    tests++;
    if (inst !== 32'h0 || inst_pc !== 32'h0 || trap_pc !== 32'h0) begin
      fails++;
      $display("[TB] FAIL reset_data: inst=%h inst_pc=%h trap_pc=%h, required all 0", inst, inst_pc, trap_pc);
    end
    reset = 1'b1;
    step();
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      fails++;
      $display("[TB] FAIL first_req: req=%b addr=%h, required 1 %h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    int prev;
    int seen;
    do_reset();
    step();
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      fails++;
      $display("[TB] FAIL seq_first_fetch: req=%b addr=%h, required 1 00000000", imem_req, imem_addr);
    end
    inst_ready = 1'b1;
    prev = 0;
    seen = 0;
    for (int i = 0; i < 30 && seen < 3; i++) begin
      if (inst_valid === 1'b1) begin
        tests++;
        if (inst_pc !== 32'(seen * 4) || inst !== mem_word(32'(seen * 4))) begin
          fails++;
          $display("[TB] FAIL seq_inst: inst_pc=%h inst=%h, required %h %h", inst_pc, inst, 32'(seen * 4), mem_word(32'(seen * 4)));
        end
        if (seen > 0) begin
          tests++;
          if (i - prev != 3) begin
            fails++;
            $display("[TB] FAIL seq_spacing: %0d cycles between instructions, required 3", i - prev);
          end
        end
        prev = i;
        seen++;
      end
      step();
    end
    tests++;
    if (seen != 3) begin
      fails++;
      $display("[TB] FAIL seq_count: %0d instructions delivered, required 3", seen);
    end
    clear_inputs();
  endtask

  task automatic test_redirect();
    bit ok;
    do_reset();
    flush_valid = 1'b1;
    flush_pc    = 32'h10;
    step();
    clear_inputs();
    wait_valid(20, ok);
    tests++;
    if (!ok || inst_pc !== 32'h10) begin
      fails++;
      $display("[TB] FAIL redirect_setup: valid=%b inst_pc=%h, required 1 00000010", ok, inst_pc);
    end
    inst_ready      = 1'b1;
    redirect_valid  = 1'b1;
    redirect_offset = 32'hFFFF_FFF8;
    step();
    clear_inputs();
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8 || inst_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL redirect_target: req=%b addr=%h valid=%b, required 1 00000008 0", imem_req, imem_addr, inst_valid);
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [31:0] held_pc;
    logic [31:0] held_inst;
    do_reset();
    wait_valid(20, ok);
    held_pc   = inst_pc;
    held_inst = inst;
    tests++;
    if (!ok || held_pc !== RESET_PC) begin
      fails++;
      $display("[TB] FAIL stall_setup: valid=%b inst_pc=%h, required 1 %h", ok, held_pc, RESET_PC);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (inst_valid !== 1'b1 || inst_pc !== held_pc || inst !== held_inst || imem_req !== 1'b0) begin
        fails++;
        $display("[TB] FAIL stall_hold: valid=%b inst_pc=%h inst=%h req=%b, required 1 %h %h 0", inst_valid, inst_pc, inst, imem_req, held_pc, held_inst);
      end
    end
    inst_ready = 1'b1;
    step();
    clear_inputs();
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== held_pc + 32'd4) begin
      fails++;
      $display("[TB] FAIL stall_release: req=%b addr=%h, required 1 %h", imem_req, imem_addr, held_pc + 32'd4);
    end
  endtask

  task automatic test_flush_wait();
    bit got;
    bit ok;
    bit got_first;
    logic [31:0] first_addr;
    do_reset();
    extra_lo = 2;
    extra_hi = 2;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (imem_gnt === 1'b1) got = 1'b1;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("[TB] FAIL flush_wait_grant: no grant seen, required one within 10 cycles");
    end
    step();
    flush_valid = 1'b1;
    flush_pc    = 32'h200;
    step();
    clear_inputs();
    ok = 1'b0;
    got_first = 1'b0;
    first_addr = 32'h0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (inst_valid === 1'b1) ok = 1'b1;
      else begin
        if (imem_gnt === 1'b1 && !got_first) begin
          first_addr = imem_addr;
          got_first  = 1'b1;
        end
        step();
      end
    end
    tests++;
    if (!ok || inst_pc !== 32'h200 || inst !== mem_word(32'h200)) begin
      fails++;
      $display("[TB] FAIL flush_wait_inst: valid=%b inst_pc=%h inst=%h, required 1 00000200 %h", ok, inst_pc, inst, mem_word(32'h200));
    end
    tests++;
    if (!got_first || first_addr !== 32'h200) begin
      fails++;
      $display("[TB] FAIL flush_wait_refetch: granted=%b addr=%h, required 1 00000200", got_first, first_addr);
    end
  endtask

  task automatic test_flush_priority();
    bit ok;
    do_reset();
    wait_valid(20, ok);
    tests++;
    if (!ok || inst_pc !== RESET_PC) begin
      fails++;
      $display("[TB] FAIL prio_setup: valid=%b inst_pc=%h, required 1 %h", ok, inst_pc, RESET_PC);
    end
    inst_ready      = 1'b1;
    redirect_valid  = 1'b1;
    redirect_offset = 32'h40;
    flush_valid     = 1'b1;
    flush_pc        = 32'h300;
    step();
    clear_inputs();
    tests++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      fails++;
      $display("[TB] FAIL prio_fetch: valid=%b req=%b addr=%h, required 0 1 00000300", inst_valid, imem_req, imem_addr);
    end
    wait_valid(20, ok);
    tests++;
    if (!ok || inst_pc !== 32'h300 || inst !== mem_word(32'h300)) begin
      fails++;
      $display("[TB] FAIL prio_inst: valid=%b inst_pc=%h inst=%h, required 1 00000300 %h", ok, inst_pc, inst, mem_word(32'h300));
    end
  endtask

  task automatic test_misalign();
    bit ok;
    do_reset();
    wait_valid(20, ok);
    tests++;
    if (!ok || inst_pc !== RESET_PC) begin
      fails++;
      $display("[TB] FAIL misalign_setup: valid=%b inst_pc=%h, required 1 %h", ok, inst_pc, RESET_PC);
    end
    inst_ready      = 1'b1;
    redirect_valid  = 1'b1;
    redirect_offset = 32'h6;
    step();
    clear_inputs();
`ifdef PC_MISALIGN_TRAP_EN
    tests++;
    if (trap_valid !== 1'b1 || trap_pc !== 32'h6) begin
      fails++;
      $display("[TB] FAIL misalign_trap: trap_valid=%b trap_pc=%h, required 1 00000006", trap_valid, trap_pc);
    end
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      fails++;
      $display("[TB] FAIL misalign_restart: req=%b addr=%h, required 1 %h", imem_req, imem_addr, RESET_PC);
    end
    step();
    tests++;
    if (trap_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL misalign_pulse: trap_valid=%b, required 0", trap_valid);
    end
`else
    tests++;
    if (trap_valid !== 1'b0 || trap_pc !== 32'h0) begin
      fails++;
      $display("[TB] FAIL misalign_tied: trap_valid=%b trap_pc=%h, required 0 00000000", trap_valid, trap_pc);
    end
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      fails++;
      $display("[TB] FAIL misalign_align: req=%b addr=%h, required 1 00000004", imem_req, imem_addr);
    end
    wait_valid(20, ok);
    tests++;
    if (!ok || inst_pc !== 32'h4) begin
      fails++;
      $display("[TB] FAIL misalign_inst: valid=%b inst_pc=%h, required 1 00000004", ok, inst_pc);
    end
`endif
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    flush_valid = 1'b1;
    flush_pc    = 32'hFFFF_FFFC;
    step();
    clear_inputs();
    wait_valid(20, ok);
    tests++;
    if (!ok || inst_pc !== 32'hFFFF_FFFC || inst !== mem_word(32'hFFFF_FFFC)) begin
      fails++;
      $display("[TB] FAIL wrap_setup: valid=%b inst_pc=%h, required 1 fffffffc", ok, inst_pc);
    end
    inst_ready = 1'b1;
    step();
    clear_inputs();
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      fails++;
      $display("[TB] FAIL wrap_next: req=%b addr=%h, required 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] off;
    bit expect_gap;
    bit do_flush;
    int retired;
    do_reset();
    gnt_pct  = 60;
    extra_lo = 0;
    extra_hi = 3;
    exp_pc = RESET_PC;
    expect_gap = 1'b0;
    retired = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (expect_gap) begin
        tests++;
        if (inst_valid !== 1'b0) begin
          fails++;
          $display("[TB] FAIL rand_flush_gap: inst_valid=%b after flush, required 0", inst_valid);
        end
        expect_gap = 1'b0;
      end else if (inst_valid === 1'b1) begin
        tests++;
        if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
          fails++;
          $display("[TB] FAIL rand_inst: inst_pc=%h inst=%h, required %h %h", inst_pc, inst, exp_pc, mem_word(exp_pc));
        end
      end
      tests++;
      if (trap_valid !== 1'b0) begin
        fails++;
        $display("[TB] FAIL rand_trap: trap_valid=%b on aligned targets, required 0", trap_valid);
      end
      do_flush        = ($urandom_range(0, 99) < 4);
      off             = ($urandom_range(0, 64) * 32'd4) - 32'd128;
      inst_ready      = ($urandom_range(0, 9) < 6);
      redirect_valid  = ($urandom_range(0, 3) == 0);
      redirect_offset = off;
      flush_valid     = do_flush;
      flush_pc        = $urandom & 32'hFFFF_FFFC;
      if (do_flush) begin
        exp_pc     = flush_pc;
        expect_gap = 1'b1;
      end else if (inst_valid === 1'b1 && inst_ready) begin
        exp_pc = redirect_valid ? exp_pc + off : exp_pc + 32'd4;
        retired++;
      end
    end
    clear_inputs();
    tests++;
    if (retired < 20) begin
      fails++;
      $display("[TB] FAIL rand_progress: %0d instructions retired, required at least 20", retired);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_stall();
    test_flush_wait();
    test_flush_priority();
    test_misalign();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
